// File: rtl/full_adder_pkg.sv
// full_adder_pkg: shared constants and types for the full_adder cell.
// Holds the default counter width, the {cout, sum} result pair and the
// counter saturation value for the default width.
`timescale 1ns/1ps

package full_adder_pkg;

    // Default width of the carry-event counter.
    localparam int CNT_W_DEF = 8;

    // Saturation value of the carry-event counter at the default width.
    localparam logic [CNT_W_DEF-1:0] CNT_SAT_DEF = '1;

    // Two-bit adder result; packing order makes {cout, sum} == a + b + cin.
    typedef struct packed {
        logic cout;
        logic sum;
    } fa_result_t;

    // Behavioural reference: 2-bit arithmetic sum of three single bits.
    function automatic fa_result_t fa_ref(input logic a, input logic b, input logic cin);
        return fa_result_t'(2'(a) + 2'(b) + 2'(cin));
    endfunction

endpackage

// File: rtl/full_adder_half_adder.sv
// half_adder: single-bit half adder, s = a ^ b, c = a & b.
// Two of these plus an OR gate form the full adder.
`timescale 1ns/1ps

module half_adder (
    input  logic a,
    input  logic b,
    output logic s,
    output logic c
);

    assign s = a ^ b;
    assign c = a & b;

endmodule

// File: rtl/full_adder.sv
// full_adder: single-bit full adder with combinational sum/carry, a
// registered copy of the result and a saturating carry-event counter.
// Optional feature macro: FULL_ADDER_SELFCHECK_EN enables a per-edge
// comparison of the gate-level result against a behavioural sum and a
// sticky o_err flag; without it o_err is tied low.
`timescale 1ns/1ps

module full_adder
    import full_adder_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             i_a,
    input  logic             i_b,
    input  logic             i_cin,
    output logic             o_sum,
    output logic             o_cout,
    input  logic             i_clk,
    input  logic             i_rst_n,
    output logic             o_sum_q,
    output logic             o_cout_q,
    output logic [CNT_W-1:0] o_carry_cnt,
    output logic             o_err
);

    // Counter holds here instead of wrapping.
    localparam logic [CNT_W-1:0] CNT_SAT = '1;

    logic s1;  // a ^ b
    logic c1;  // a & b
    logic c2;  // (a ^ b) & cin

    half_adder u_ha_ab (
        .a (i_a),
        .b (i_b),
        .s (s1),
        .c (c1)
    );

    half_adder u_ha_cin (
        .a (s1),
        .b (i_cin),
        .s (o_sum),
        .c (c2)
    );

    assign o_cout = c1 | c2;

    // Registered copy of the combinational result, cleared asynchronously.
    // NOTE: state is updated with non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_sum_q  <= 1'b0;
            o_cout_q <= 1'b0;
        end else begin
            o_sum_q  <= o_sum;
            o_cout_q <= o_cout;
        end
    end

    // Count edges on which the carry is high, saturating at all-ones.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_carry_cnt <= '0;
        end else if (o_cout && (o_carry_cnt != CNT_SAT)) begin
            o_carry_cnt <= o_carry_cnt + CNT_W'(1);
        end
    end

`ifdef FULL_ADDER_SELFCHECK_EN
    fa_result_t gate_res;
    fa_result_t beh_res;

    assign gate_res = '{cout: o_cout, sum: o_sum};
    assign beh_res  = fa_ref(i_a, i_b, i_cin);

    // Sticky error: any edge where the gate network disagrees with the
    // behavioural sum sets o_err until the next reset.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_err <= 1'b0;
        end else if (gate_res != beh_res) begin
            o_err <= 1'b1;
        end
    end
`else
    assign o_err = 1'b0;
`endif

endmodule

// File: tb/tb_full_adder.sv
// tb_full_adder: directed bench for full_adder. A default-width instance
// covers the combinational truth table, registered path, async reset and
// idle counter; a CNT_W=2 instance sharing the same inputs covers saturation.
`timescale 1ns/1ps

module tb_full_adder;

    logic       i_clk;
    logic       i_rst_n;
    logic       i_a, i_b, i_cin;

    logic       o_sum, o_cout, o_sum_q, o_cout_q, o_err;
    logic [7:0] o_carry_cnt;

    logic       n_sum, n_cout, n_sum_q, n_cout_q, n_err;
    logic [1:0] n_carry_cnt;

    int errors = 0;
    int checks = 0;

    full_adder dut (
        .i_a         (i_a),
        .i_b         (i_b),
        .i_cin       (i_cin),
        .o_sum       (o_sum),
        .o_cout      (o_cout),
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .o_sum_q     (o_sum_q),
        .o_cout_q    (o_cout_q),
        .o_carry_cnt (o_carry_cnt),
        .o_err       (o_err)
    );

    full_adder #(.CNT_W(2)) dut_narrow (
        .i_a         (i_a),
        .i_b         (i_b),
        .i_cin       (i_cin),
        .o_sum       (n_sum),
        .o_cout      (n_cout),
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .o_sum_q     (n_sum_q),
        .o_cout_q    (n_cout_q),
        .o_carry_cnt (n_carry_cnt),
        .o_err       (n_err)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic a, input logic b, input logic cin);
        i_a   = a;
        i_b   = b;
        i_cin = cin;
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] exp_tt [8];
        logic [1:0] exp_sat [6];
        exp_tt  = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};
        exp_sat = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3, 2'd3};

        // Reset state
        i_rst_n = 1'b0;
        drive(1'b0, 1'b0, 1'b0);
        #1;
        check("rst_sum_q",  {31'd0, o_sum_q},  32'd0);
        check("rst_cout_q", {31'd0, o_cout_q}, 32'd0);
        check("rst_cnt",    {24'd0, o_carry_cnt}, 32'd0);
        check("rst_cnt_n",  {30'd0, n_carry_cnt}, 32'd0);
        check("rst_err",    {31'd0, o_err},    32'd0);

        // Exhaustive combinational truth table (registers held in reset)
        for (int i = 0; i < 8; i++) begin
            drive(i[2], i[1], i[0]);
            #5;
            check($sformatf("tt_%0d", i), {30'd0, o_cout, o_sum}, {30'd0, exp_tt[i]});
            check($sformatf("tt_n_%0d", i), {30'd0, n_cout, n_sum}, {30'd0, exp_tt[i]});
        end
        check("tt_rst_hold_sum_q", {31'd0, o_sum_q}, 32'd0);

        // Registered path: 1,0,0 then 1,1,0
        @(negedge i_clk);
        i_rst_n = 1'b1;
        drive(1'b1, 1'b0, 1'b0);
        step();
        check("reg_100_sum_q",  {31'd0, o_sum_q},  32'd1);
        check("reg_100_cout_q", {31'd0, o_cout_q}, 32'd0);
        check("reg_100_cnt",    {24'd0, o_carry_cnt}, 32'd0);
        @(negedge i_clk);
        drive(1'b1, 1'b1, 1'b0);
        #1;
        check("reg_pre_sum_q",  {31'd0, o_sum_q},  32'd1);
        check("reg_pre_cout_q", {31'd0, o_cout_q}, 32'd0);

        // Counter saturation on the 2-bit instance, 6 edges of 1,1,0
        for (int e = 0; e < 6; e++) begin
            step();
            check($sformatf("sat_cnt_n_%0d", e), {30'd0, n_carry_cnt}, {30'd0, exp_sat[e]});
            check($sformatf("sat_cnt_%0d", e),   {24'd0, o_carry_cnt}, e + 1);
            if (e == 0) begin
                check("reg_110_sum_q",  {31'd0, o_sum_q},  32'd0);
                check("reg_110_cout_q", {31'd0, o_cout_q}, 32'd1);
            end
        end

        // Async reset mid-operation with 1,1,1
        @(negedge i_clk);
        drive(1'b1, 1'b1, 1'b1);
        step();
        step();
        step();
        check("pre_arst_sum_q",  {31'd0, o_sum_q},  32'd1);
        check("pre_arst_cout_q", {31'd0, o_cout_q}, 32'd1);
        check("pre_arst_cnt",    {24'd0, o_carry_cnt}, 32'd9);
        #1;
        i_rst_n = 1'b0;
        #1;
        check("arst_sum_q",  {31'd0, o_sum_q},  32'd0);
        check("arst_cout_q", {31'd0, o_cout_q}, 32'd0);
        check("arst_cnt",    {24'd0, o_carry_cnt}, 32'd0);
        check("arst_cnt_n",  {30'd0, n_carry_cnt}, 32'd0);
        check("arst_sum",    {31'd0, o_sum},    32'd1);
        check("arst_cout",   {31'd0, o_cout},   32'd1);
        step();
        check("arst_hold_cnt", {24'd0, o_carry_cnt}, 32'd0);

        // Counter idle: 1,0,0 for 10 edges
        @(negedge i_clk);
        i_rst_n = 1'b1;
        drive(1'b1, 1'b0, 1'b0);
        for (int e = 0; e < 10; e++) begin
            step();
            check($sformatf("idle_cnt_%0d", e), {24'd0, o_carry_cnt}, 32'd0);
        end
        check("idle_sum_q",  {31'd0, o_sum_q},  32'd1);
        check("idle_cout_q", {31'd0, o_cout_q}, 32'd0);
        check("idle_err",    {31'd0, o_err},    32'd0);

`ifdef FULL_ADDER_SELFCHECK_EN
        // Fault injection on the first half-adder carry
        @(negedge i_clk);
        drive(1'b1, 1'b1, 1'b0);
        force dut.c1 = 1'b0;
        #1;
        check("sc_pre_err", {31'd0, o_err}, 32'd0);
        step();
        check("sc_err_set", {31'd0, o_err}, 32'd1);
        release dut.c1;
        step();
        check("sc_err_sticky", {31'd0, o_err}, 32'd1);
        i_rst_n = 1'b0;
        #1;
        check("sc_err_clr", {31'd0, o_err}, 32'd0);
        @(negedge i_clk);
        i_rst_n = 1'b1;
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
